// File: rtl/modexp_pkg.sv
// modexp_pkg
// Shared definitions for the modular-exponentiation sequencer: FSM state
// encoding, multiplier operand-select encodings and datapath width of the
// ONE operand.
package modexp_pkg;

  // Width of the datapath operands, including the ONE constant fed on port B.
  localparam int OPERAND_W = 1024;
  localparam int ONE_W     = OPERAND_W;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_XT_ISSUE  = 4'd1,
    S_XT_WAIT   = 4'd2,
    S_A_INIT    = 4'd3,
    S_SQ_ISSUE  = 4'd4,
    S_SQ_WAIT   = 4'd5,
    S_MUL_ISSUE = 4'd6,
    S_MUL_WAIT  = 4'd7,
    S_NEXT      = 4'd8,
    S_FIN_ISSUE = 4'd9,
    S_FIN_WAIT  = 4'd10,
    S_DONE      = 4'd11
  } state_t;

  // Multiplier port A operand selects
  localparam logic [1:0] A_SEL_X      = 2'd0;
  localparam logic [1:0] A_SEL_AREG   = 2'd1;
  localparam logic [1:0] A_SEL_RMODM  = 2'd2;

  // Multiplier port B operand selects
  localparam logic [1:0] B_SEL_R2MODM = 2'd0;
  localparam logic [1:0] B_SEL_AREG   = 2'd1;
  localparam logic [1:0] B_SEL_XT     = 2'd2;
  localparam logic [1:0] B_SEL_ONE    = 2'd3;

endpackage

// File: rtl/modexp_ctrl_exp_bit_scanner.sv
// exp_bit_scanner
// Holds the exponent left-aligned so the bit under test is always the MSB,
// together with a down-counter of remaining exponent bits.
// Ports:
//   clk, resetn      clock, async active-low reset
//   load             capture exp_in/exp_len (start accepted)
//   shift            advance to the next lower exponent bit
//   exp_in, exp_len  exponent and significant-bit count (clamped to EXP_W)
//   cur_bit          exponent bit for the current loop iteration
//   last_bit         the current iteration is the final one
//   empty            no exponent bits remain
import modexp_pkg::*;

module exp_bit_scanner #(
  parameter int EXP_W = 1024,
  parameter int CNT_W = $clog2(EXP_W + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             shift,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [CNT_W-1:0] exp_len,
  output logic             cur_bit,
  output logic             last_bit,
  output logic             empty
);

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(EXP_W);

  logic [EXP_W-1:0] exp_reg;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_clamped;

  assign len_clamped = (exp_len > LEN_MAX) ? LEN_MAX : exp_len;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_reg <= '0;
      cnt     <= '0;
    end else if (load) begin
      // Pre-align so E[t-1] lands in the MSB; bits above t fall off the top.
      exp_reg <= exp_in << (LEN_MAX - len_clamped);
      cnt     <= len_clamped;
    end else if (shift && (cnt != '0)) begin
      exp_reg <= exp_reg << 1;
      cnt     <= cnt - CNT_W'(1);
    end
  end

  assign cur_bit  = exp_reg[EXP_W-1];
  assign last_bit = (cnt == CNT_W'(1));
  assign empty    = (cnt == '0);

endmodule

// File: rtl/modexp_ctrl.sv
// modexp_ctrl
// Sequencer for A = X^E mod M (left-to-right binary method) on one shared
// Montgomery multiplier. Operand registers live in the datapath; this block
// drives operand selects, register loads and multiplier launches.
// Ports:
//   clk, resetn          clock, async active-low reset
//   start                run request, honoured only in IDLE
//   exp_in, exp_len      exponent E and significant bit count t
//   busy                 run in progress (XT_ISSUE through DONE)
//   done                 one-cycle pulse, result valid in Areg
//   mm_start, mm_done    multiplier launch pulse / completion pulse
//   mm_a_sel, mm_b_sel   multiplier operand selects
//   ld_xt, ld_a          capture multiplier result into Xtreg / Areg
//   ld_a_init            copy RmodM into Areg
//
// state     | meaning
// IDLE      | waiting for start
// XT_ISSUE  | launch Xt = MM(X, R2modM)
// XT_WAIT   | wait for Xt product, load Xtreg
// A_INIT    | Areg <= RmodM
// SQ_ISSUE  | launch A = MM(A, A)
// SQ_WAIT   | wait for square, load Areg
// MUL_ISSUE | launch A = MM(A, Xt) for a set exponent bit
// MUL_WAIT  | wait for multiply, load Areg
// NEXT      | step to next exponent bit
// FIN_ISSUE | launch A = MM(A, ONE) to leave Montgomery domain
// FIN_WAIT  | wait for final product, load Areg
// DONE      | one-cycle completion pulse
import modexp_pkg::*;

module modexp_ctrl #(
  parameter int EXP_W = 1024,
  parameter int CNT_W = $clog2(EXP_W + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [CNT_W-1:0] exp_len,
  output logic             busy,
  output logic             done,
  output logic             mm_start,
  input  logic             mm_done,
  output logic [1:0]       mm_a_sel,
  output logic [1:0]       mm_b_sel,
  output logic             ld_xt,
  output logic             ld_a,
  output logic             ld_a_init
);

  state_t state;
  logic   scan_load;
  logic   scan_shift;
  logic   cur_bit;
  logic   last_bit;
  logic   scan_empty;

  assign scan_load  = (state == S_IDLE) && start;
  assign scan_shift = (state == S_NEXT);

  exp_bit_scanner #(
    .EXP_W (EXP_W),
    .CNT_W (CNT_W)
  ) u_scanner (
    .clk      (clk),
    .resetn   (resetn),
    .load     (scan_load),
    .shift    (scan_shift),
    .exp_in   (exp_in),
    .exp_len  (exp_len),
    .cur_bit  (cur_bit),
    .last_bit (last_bit),
    .empty    (scan_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (start) state <= S_XT_ISSUE;
        S_XT_ISSUE:  state <= S_XT_WAIT;
        S_XT_WAIT:   if (mm_done) state <= S_A_INIT;
        S_A_INIT:    state <= scan_empty ? S_FIN_ISSUE : S_SQ_ISSUE;
        S_SQ_ISSUE:  state <= S_SQ_WAIT;
        S_SQ_WAIT:   if (mm_done) state <= cur_bit ? S_MUL_ISSUE : S_NEXT;
        S_MUL_ISSUE: state <= S_MUL_WAIT;
        S_MUL_WAIT:  if (mm_done) state <= S_NEXT;
        // last_bit is checked before the decrement lands, i.e. counter reaches 0 here
        S_NEXT:      state <= last_bit ? S_FIN_ISSUE : S_SQ_ISSUE;
        S_FIN_ISSUE: state <= S_FIN_WAIT;
        S_FIN_WAIT:  if (mm_done) state <= S_DONE;
        S_DONE:      state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end

  // Loads follow mm_done combinationally so the datapath captures the
  // product on the same edge the FSM leaves the WAIT state.
  always_comb begin
    busy      = (state != S_IDLE);
    done      = 1'b0;
    mm_start  = 1'b0;
    mm_a_sel  = A_SEL_X;
    mm_b_sel  = B_SEL_R2MODM;
    ld_xt     = 1'b0;
    ld_a      = 1'b0;
    ld_a_init = 1'b0;
    case (state)
      S_XT_ISSUE: begin
        mm_start = 1'b1;
      end
      S_XT_WAIT: begin
        ld_xt = mm_done;
      end
      S_A_INIT: begin
        ld_a_init = 1'b1;
      end
      S_SQ_ISSUE: begin
        mm_start = 1'b1;
        mm_a_sel = A_SEL_AREG;
        mm_b_sel = B_SEL_AREG;
      end
      S_SQ_WAIT: begin
        mm_a_sel = A_SEL_AREG;
        mm_b_sel = B_SEL_AREG;
        ld_a     = mm_done;
      end
      S_MUL_ISSUE: begin
        mm_start = 1'b1;
        mm_a_sel = A_SEL_AREG;
        mm_b_sel = B_SEL_XT;
      end
      S_MUL_WAIT: begin
        mm_a_sel = A_SEL_AREG;
        mm_b_sel = B_SEL_XT;
        ld_a     = mm_done;
      end
      S_FIN_ISSUE: begin
        mm_start = 1'b1;
        mm_a_sel = A_SEL_AREG;
        mm_b_sel = B_SEL_ONE;
      end
      S_FIN_WAIT: begin
        mm_a_sel = A_SEL_AREG;
        mm_b_sel = B_SEL_ONE;
        ld_a     = mm_done;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
